// File: rtl/frame_read_if.sv
// Burst-read bus toward the DDR/AXI master plus the RGB565 pixel stream of frame_read.
// FRAME_READ_MARK_EN adds the pix_eol/pix_eof markers to the pixel stream.
`timescale 1ns/1ps
interface frame_read_if;
   logic         rd_burst_req;
   logic [7:0]   rd_burst_len;
   logic [27:0]  rd_burst_addr;
   logic         rd_burst_data_valid;
   logic [255:0] rd_burst_data;
   logic         rd_burst_finish;
   logic         pix_valid;
   logic         pix_ready;
   logic [15:0]  pix_data;
`ifdef FRAME_READ_MARK_EN
   logic         pix_eol;
   logic         pix_eof;

   modport master (
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      output pix_valid, pix_data, pix_eol, pix_eof,
      input  pix_ready
   );

   modport slave (
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      input  pix_valid, pix_data, pix_eol, pix_eof,
      output pix_ready
   );
`else
   modport master (
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      output pix_valid, pix_data,
      input  pix_ready
   );

   modport slave (
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      input  pix_valid, pix_data,
      output pix_ready
   );
`endif
endinterface

// File: rtl/frame_read.sv
// Fetches one scaled frame from DDR line by line in bursts, buffers beats in a 256-bit FIFO
// and unpacks them to an RGB565 valid/ready stream. Optional markers: FRAME_READ_MARK_EN.
`timescale 1ns/1ps
module frame_read #(
   parameter int BURST_LEN       = 16,
   parameter int IMG_COL         = 1280,
   parameter int IMG_ROW         = 720,
   parameter int SCALE           = 2,
   parameter int LINE_BURST_NUM  = IMG_COL * 16 / SCALE / 256,
   parameter int LINE_ADDR_ADD   = 8 * 2 * IMG_COL * 16 / 256 / SCALE,
   parameter int FIFO_ADDR_WIDTH = 6
) (
   input  logic         axi_aclk,
   input  logic         axi_rst,
   input  logic         read_req,
   input  logic [27:0]  read_addr,
   output logic         read_done,
   output logic         busy,
   frame_read_if.master bus
);

   localparam int                     FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
   localparam logic [15:0]            BURSTS_PER_LINE = 16'(LINE_BURST_NUM);
   localparam logic [15:0]            MAX_BURST       = 16'(BURST_LEN);
   localparam logic [15:0]            LINE_NUM        = 16'(IMG_ROW / SCALE);
   localparam logic [15:0]            DEPTH16         = 16'(FIFO_DEPTH);
   localparam logic [27:0]            LINE_STRIDE     = 28'(LINE_ADDR_ADD);
   localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL    = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE     = (FIFO_ADDR_WIDTH + 1)'(1);
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE     = FIFO_ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_LINE_START  = 3'd1,
      S_BURST_ISSUE = 3'd2,
      S_BURST_WAIT  = 3'd3,
      S_LINE_DONE   = 3'd4,
      S_DRAIN       = 3'd5,
      S_DONE        = 3'd6
   } state_t;

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic                     req_q_r;
   logic                     req_prev_r;
   logic                     req_rise_s;
   logic [27:0]              line_base_r;
   logic [15:0]              line_cnt_r;
   logic [15:0]              burst_cnt_r;
   logic [7:0]               outstanding_r;
   logic                     rd_burst_req_r;
   logic [7:0]               rd_burst_len_r;
   logic [27:0]              rd_burst_addr_r;
   logic                     busy_r;
   logic                     read_done_r;
   logic [15:0]              remain_s;
   logic [15:0]              len_s;
   logic                     space_ok_s;
   logic                     accept_s;
   logic                     issue_s;
   logic                     finish_s;
   logic                     line_end_s;

   logic [255:0]             mem_r [FIFO_DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_r;
   logic [FIFO_ADDR_WIDTH:0]   count_r;
   logic                     fifo_empty_s;
   logic                     fifo_full_s;
   logic                     fifo_wr_s;
   logic                     fifo_rd_s;
   logic [255:0]             fifo_rdata_s;

   logic [255:0]             word_r;
   logic [3:0]               idx_r;
   logic [3:0]               idx_inc_s;
   logic                     hold_r;
   logic [15:0]              pix_data_r;
   logic                     pix_take_s;
   logic                     last_take_s;
   logic                     load_s;

   assign req_rise_s   = req_q_r & ~req_prev_r;
   assign fifo_empty_s = (count_r == '0);
   assign fifo_full_s  = (count_r == CNT_FULL);
   assign fifo_rdata_s = mem_r[rd_ptr_r];
   assign line_end_s   = (burst_cnt_r == BURSTS_PER_LINE);

   // Burst sizing and FIFO-space admission for the next burst of the line
   always_comb begin
      remain_s   = BURSTS_PER_LINE - burst_cnt_r;
      len_s      = MAX_BURST;
      if (remain_s < MAX_BURST) begin
         len_s = remain_s;
      end else begin
         len_s = MAX_BURST;
      end
      // Beats already promised to an in-flight burst count as occupied space.
      space_ok_s = (16'(count_r) + 16'(outstanding_r) + len_s) <= DEPTH16;
   end

   // Command edge detect on the registered read_req
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         req_q_r    <= 1'b0;
         req_prev_r <= 1'b0;
      end else begin
         req_q_r    <= read_req;
         req_prev_r <= req_q_r;
      end
   end

   // FSM state register
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state and control strobes
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      issue_s     = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_rise_s) begin
               accept_s    = 1'b1;
               state_nxt_s = S_LINE_START;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_LINE_START: state_nxt_s = S_BURST_ISSUE;
         S_BURST_ISSUE: begin
            if (space_ok_s) begin
               issue_s     = 1'b1;
               state_nxt_s = S_BURST_WAIT;
            end else begin
               state_nxt_s = S_BURST_ISSUE;
            end
         end
         S_BURST_WAIT: begin
            if (bus.rd_burst_finish) begin
               finish_s    = 1'b1;
               state_nxt_s = line_end_s ? S_LINE_DONE : S_BURST_ISSUE;
            end else begin
               state_nxt_s = S_BURST_WAIT;
            end
         end
         S_LINE_DONE: begin
            if (line_cnt_r >= LINE_NUM) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_LINE_START;
            end
         end
         S_DRAIN: begin
            if (fifo_empty_s && !hold_r) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_DRAIN;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Line/burst bookkeeping and frame addressing
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         line_base_r <= 28'd0;
         line_cnt_r  <= 16'd0;
         burst_cnt_r <= 16'd0;
      end else begin
         if (accept_s) begin
            line_base_r <= read_addr;
         end else if (state_r == S_LINE_DONE) begin
            line_base_r <= line_base_r + LINE_STRIDE;
         end
         if (accept_s) begin
            line_cnt_r <= 16'd0;
         end else if (finish_s && line_end_s) begin
            line_cnt_r <= line_cnt_r + 16'd1;
         end
         if (accept_s || (state_r == S_LINE_START)) begin
            burst_cnt_r <= 16'd0;
         end else if (issue_s) begin
            burst_cnt_r <= burst_cnt_r + len_s;
         end
      end
   end

   // Burst request outputs, held stable until the burst finishes
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         rd_burst_req_r  <= 1'b0;
         rd_burst_len_r  <= 8'd16;
         rd_burst_addr_r <= 28'd0;
      end else if (issue_s) begin
         rd_burst_req_r  <= 1'b1;
         rd_burst_len_r  <= len_s[7:0];
         rd_burst_addr_r <= line_base_r + {9'd0, burst_cnt_r, 3'b000};
      end else if (finish_s) begin
         rd_burst_req_r  <= 1'b0;
      end
   end

   // Beats still expected from the current burst
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         outstanding_r <= 8'd0;
      end else if (issue_s) begin
         outstanding_r <= len_s[7:0];
      end else if (bus.rd_burst_data_valid && (outstanding_r != 8'd0)) begin
         outstanding_r <= outstanding_r - 8'd1;
      end
   end

   // Frame status outputs
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         busy_r      <= 1'b0;
         read_done_r <= 1'b0;
      end else begin
         busy_r      <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
         read_done_r <= (state_nxt_s == S_DONE);
      end
   end

   // A beat into a full FIFO is dropped unless a word leaves in the same cycle.
   assign fifo_rd_s = load_s;
   assign fifo_wr_s = bus.rd_burst_data_valid && (!fifo_full_s || fifo_rd_s);

   // FIFO storage
   always_ff @(posedge axi_aclk) begin
      if (fifo_wr_s) begin
         mem_r[wr_ptr_r] <= bus.rd_burst_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (fifo_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (fifo_rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({fifo_wr_s, fifo_rd_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign pix_take_s  = hold_r & bus.pix_ready;
   assign last_take_s = pix_take_s & (idx_r == 4'd15);
   assign load_s      = !fifo_empty_s && (!hold_r || last_take_s);
   assign idx_inc_s   = idx_r + 4'd1;

   // Unpacker: low halfword first, next word chained on the final transfer
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         word_r     <= 256'd0;
         idx_r      <= 4'd0;
         hold_r     <= 1'b0;
         pix_data_r <= 16'd0;
      end else if (load_s) begin
         word_r     <= fifo_rdata_s;
         idx_r      <= 4'd0;
         hold_r     <= 1'b1;
         pix_data_r <= fifo_rdata_s[15:0];
      end else if (last_take_s) begin
         idx_r      <= 4'd0;
         hold_r     <= 1'b0;
      end else if (pix_take_s) begin
         idx_r      <= idx_inc_s;
         pix_data_r <= word_r[{idx_inc_s, 4'b0000} +: 16];
      end
   end

`ifdef FRAME_READ_MARK_EN
   localparam logic [15:0] LINE_PIX = 16'(IMG_COL / SCALE);

   logic [15:0] col_cnt_r;
   logic [15:0] row_cnt_r;

   // Position of the presented pixel within the frame
   always_ff @(posedge axi_aclk) begin
      if (axi_rst || accept_s) begin
         col_cnt_r <= 16'd0;
         row_cnt_r <= 16'd0;
      end else if (pix_take_s) begin
         if (col_cnt_r == LINE_PIX - 16'd1) begin
            col_cnt_r <= 16'd0;
            row_cnt_r <= row_cnt_r + 16'd1;
         end else begin
            col_cnt_r <= col_cnt_r + 16'd1;
         end
      end
   end

   assign bus.pix_eol = hold_r && (col_cnt_r == LINE_PIX - 16'd1);
   assign bus.pix_eof = bus.pix_eol && (row_cnt_r == LINE_NUM - 16'd1);
`endif

   assign bus.rd_burst_req  = rd_burst_req_r;
   assign bus.rd_burst_len  = rd_burst_len_r;
   assign bus.rd_burst_addr = rd_burst_addr_r;
   assign bus.pix_valid     = hold_r;
   assign bus.pix_data      = pix_data_r;
   assign read_done         = read_done_r;
   assign busy              = busy_r;

endmodule

// File: tb/tb_frame_read.sv
// Directed bench for frame_read in a reduced geometry: 160x4 frame, bursts of at most 4 beats, 8-word FIFO.
`timescale 1ns/1ps
module tb_frame_read;
   localparam int LPIX      = 160;
   localparam int LNUM      = 4;
   localparam int FRAME_PIX = LPIX * LNUM;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_req;
   logic [27:0] read_addr;
   logic        read_done;
   logic        busy;

   frame_read_if bus_if ();

   frame_read #(
      .BURST_LEN(4), .IMG_COL(160), .IMG_ROW(4), .SCALE(1), .FIFO_ADDR_WIDTH(3)
   ) dut (
      .axi_aclk(clk), .axi_rst(rst), .read_req(read_req), .read_addr(read_addr),
      .read_done(read_done), .busy(busy), .bus(bus_if)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [27:0] cur_base;
   int          pix_idx;
   int          nb;
   logic [7:0]  blen [64];
   logic [27:0] baddr [64];
   int          ready_mode;
   int          done_cnt;
   int          first_beat_cyc;
   int          first_valid_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory content: pixel k of the beat at address a, numbered from the frame base.
   function automatic logic [15:0] pix_fn(input logic [27:0] a, input int k);
      logic [27:0] off;
      off = (a - cur_base) >> 3;
      return 16'(int'(off) * 16 + k + 1);
   endfunction

   function automatic logic [255:0] mk_word(input logic [27:0] a);
      logic [255:0] w;
      w = 256'd0;
      for (int k = 0; k < 16; k++) w[16*k +: 16] = pix_fn(a, k);
      return w;
   endfunction

   task automatic serve_burst(input logic [7:0] len, input logic [27:0] addr);
      for (int b = 0; b < int'(len); b++) begin
         @(negedge clk);
         if (rst) begin
            bus_if.rd_burst_data_valid = 1'b0;
            return;
         end
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
         bus_if.rd_burst_data_valid = 1'b1;
         bus_if.rd_burst_data       = mk_word(addr + 28'(b * 8));
      end
      @(negedge clk);
      bus_if.rd_burst_data_valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         if (rst) return;
      end
      bus_if.rd_burst_finish = 1'b1;
      @(negedge clk);
      bus_if.rd_burst_finish = 1'b0;
   endtask

   initial begin : mem_model
      bus_if.rd_burst_data_valid = 1'b0;
      bus_if.rd_burst_data       = 256'd0;
      bus_if.rd_burst_finish     = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bus_if.rd_burst_req === 1'b1) begin
            if (nb < 64) begin
               blen[nb]  = bus_if.rd_burst_len;
               baddr[nb] = bus_if.rd_burst_addr;
            end
            nb++;
            serve_burst(bus_if.rd_burst_len, bus_if.rd_burst_addr);
         end
      end
   end

   initial begin : pix_mon
      logic [15:0] hold_val;
      logic [15:0] exp;
      logic [27:0] a;
      bit          holding;
      bit          r;
      int          l;
      int          c;
      holding          = 1'b0;
      bus_if.pix_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            holding          = 1'b0;
            bus_if.pix_ready = 1'b0;
         end else if (bus_if.pix_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (holding) check("pix_hold", 64'(bus_if.pix_data), 64'(hold_val));
            case (ready_mode)
               0:       r = 1'b0;
               1:       r = 1'b1;
               default: r = 1'($urandom_range(0, 1));
            endcase
            bus_if.pix_ready = r;
            if (r) begin
               l   = pix_idx / LPIX;
               c   = pix_idx % LPIX;
               a   = cur_base + 28'(l * 160) + 28'((c / 16) * 8);
               exp = pix_fn(a, c % 16);
               check("pix_data", 64'(bus_if.pix_data), 64'(exp));
`ifdef FRAME_READ_MARK_EN
               check("pix_eol", 64'(bus_if.pix_eol), 64'(c == LPIX - 1));
               check("pix_eof", 64'(bus_if.pix_eof), 64'(pix_idx == FRAME_PIX - 1));
`endif
               pix_idx++;
               holding = 1'b0;
            end else begin
               holding  = 1'b1;
               hold_val = bus_if.pix_data;
            end
         end else begin
            if (holding) check("pix_valid_held", 64'(bus_if.pix_valid), 64'd1);
            holding          = 1'b0;
            bus_if.pix_ready = 1'b0;
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(negedge clk);
         if (read_done === 1'b1) done_cnt++;
      end
   end

   task automatic start_frame(input logic [27:0] base);
      cur_base        = base;
      pix_idx         = 0;
      nb              = 0;
      first_beat_cyc  = -1;
      first_valid_cyc = -1;
      read_addr       = base;
      @(negedge clk);
      read_req = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (read_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   initial begin : main
      bit found;
      rst = 1'b1; read_req = 1'b0; read_addr = 28'd0; cur_base = 28'd0;
      pix_idx = 0; nb = 0; ready_mode = 1; done_cnt = 0;
      first_beat_cyc = -1; first_valid_cyc = -1;
      repeat (3) @(negedge clk);
      check("rst_req",   64'(bus_if.rd_burst_req),  64'd0);
      check("rst_len",   64'(bus_if.rd_burst_len),  64'd16);
      check("rst_addr",  64'(bus_if.rd_burst_addr), 64'd0);
      check("rst_valid", 64'(bus_if.pix_valid),     64'd0);
      check("rst_pix",   64'(bus_if.pix_data),      64'd0);
      check("rst_busy",  64'(busy),                 64'd0);
      check("rst_done",  64'(read_done),            64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Frame 1: always ready, burst split and line stride
      ready_mode = 1;
      start_frame(28'h0100000);
      repeat (3) @(negedge clk);
      check("f1_busy", 64'(busy), 64'd1);
      read_req = 1'b0;
      wait_done("f1", 5000);
      check("f1_pixels", 64'(pix_idx), 64'(FRAME_PIX));
      check("f1_bursts", 64'(nb), 64'd12);
      check("f1_b0_len", 64'(blen[0]), 64'd4);   check("f1_b0_addr", 64'(baddr[0]), 64'h0100000);
      check("f1_b1_len", 64'(blen[1]), 64'd4);   check("f1_b1_addr", 64'(baddr[1]), 64'h0100020);
      check("f1_b2_len", 64'(blen[2]), 64'd2);   check("f1_b2_addr", 64'(baddr[2]), 64'h0100040);
      check("f1_b3_len", 64'(blen[3]), 64'd4);   check("f1_b3_addr", 64'(baddr[3]), 64'h01000A0);
      check("f1_b11_len", 64'(blen[11]), 64'd2); check("f1_b11_addr", 64'(baddr[11]), 64'h0100220);
      check("f1_latency", 64'((first_valid_cyc - first_beat_cyc >= 1) &&
                              (first_valid_cyc - first_beat_cyc <= 3)), 64'd1);
      @(negedge clk);
      check("f1_busy_end", 64'(busy), 64'd0);
      check("f1_done_pulse", 64'(read_done), 64'd0);
      repeat (5) @(negedge clk);
      check("f1_done_cnt", 64'(done_cnt), 64'd1);

      // Frame 2: random ready, read_req toggled while busy with another address
      ready_mode = 2;
      start_frame(28'h0200000);
      repeat (30) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         read_addr = 28'h0600000;
         read_req  = ~read_req;
         repeat (7) @(negedge clk);
      end
      read_req = 1'b0;
      wait_done("f2", 8000);
      check("f2_pixels", 64'(pix_idx), 64'(FRAME_PIX));
      check("f2_bursts", 64'(nb), 64'd12);
      repeat (20) @(negedge clk);
      check("f2_done_cnt", 64'(done_cnt), 64'd2);
      check("f2_busy_end", 64'(busy), 64'd0);

      // Frame 3: downstream stalled, fetch must stop when the FIFO cannot take the next burst
      ready_mode = 0;
      start_frame(28'h0300000);
      repeat (150) @(negedge clk);
      check("f3_stall_req", 64'(bus_if.rd_burst_req), 64'd0);
      check("f3_stall_nb", 64'(nb), 64'd2);
      check("f3_stall_len0", 64'(blen[0]), 64'd4);
      check("f3_stall_len1", 64'(blen[1]), 64'd4);
      check("f3_stall_valid", 64'(bus_if.pix_valid), 64'd1);
      check("f3_stall_pix", 64'(bus_if.pix_data), 64'h0001);
      read_req   = 1'b0;
      ready_mode = 1;
      wait_done("f3", 5000);
      check("f3_pixels", 64'(pix_idx), 64'(FRAME_PIX));
      check("f3_bursts", 64'(nb), 64'd12);
      repeat (3) @(negedge clk);
      check("f3_done_cnt", 64'(done_cnt), 64'd3);

      // Frame 4: reset during a burst of the second line, then a fresh frame
      ready_mode = 1;
      start_frame(28'h0400000);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (nb >= 5 && bus_if.rd_burst_req === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("f4_reach_line2", 64'(found), 64'd1);
      read_req = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("f4_rst_req",   64'(bus_if.rd_burst_req), 64'd0);
      check("f4_rst_valid", 64'(bus_if.pix_valid),    64'd0);
      check("f4_rst_busy",  64'(busy),                64'd0);
      check("f4_rst_done",  64'(read_done),           64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("f4_no_done", 64'(done_cnt), 64'd3);
      start_frame(28'h0500000);
      repeat (3) @(negedge clk);
      read_req = 1'b0;
      wait_done("f5", 5000);
      check("f5_first_addr", 64'(baddr[0]), 64'h0500000);
      check("f5_pixels", 64'(pix_idx), 64'(FRAME_PIX));
      check("f5_bursts", 64'(nb), 64'd12);
      repeat (3) @(negedge clk);
      check("f5_done_cnt", 64'(done_cnt), 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/frame_read.md
Name: frame_read

Overview:
- Read-side counterpart of the frame writer.
- On a read command it fetches one scaled frame (IMG_ROW/SCALE lines) from DDR through the burst-read interface of the DDR/AXI master, one line at a time.
- Fetched data is buffered in an internal 256-bit FIFO, unpacked to 16-bit RGB565 pixels and presented on a valid/ready pixel stream for the output/scaler pipeline.
- Single clock domain: the fabric AXI clock.

Parameters:
- BURST_LEN, 16: maximum beats per burst (DDR IP limit).
- IMG_COL, 1280: source columns.
- IMG_ROW, 720: source rows.
- SCALE, 2: decimation factor; the frame holds IMG_ROW/SCALE lines of IMG_COL/SCALE pixels.
- LINE_BURST_NUM, IMG_COL*16/SCALE/256: 256-bit beats per line (40 at defaults).
- LINE_ADDR_ADD, 8*2*IMG_COL*16/256/SCALE: address stride between lines (640 at defaults).
- FIFO_ADDR_WIDTH, 6: internal FIFO depth is 2^FIFO_ADDR_WIDTH words of 256 bits.

Ports:
- axi_aclk  in  1  clock.
- axi_rst  in  1  synchronous active-high reset.
- read_req  in  1  level command; a rising edge starts a frame.
- read_addr  in  28  frame base address, sampled on the read_req rising edge.
- read_done  out  1  one-cycle pulse when the frame has been fetched and fully output.
- busy  out  1  high from command accept until read_done.
- rd_burst_req  out  1  burst request.
- rd_burst_len  out  8  beats in the burst.
- rd_burst_addr  out  28  burst start address.
- rd_burst_data_valid  in  1  read beat strobe.
- rd_burst_data  in  256  read beat.
- rd_burst_finish  in  1  one-cycle pulse at burst completion.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  16  RGB565 pixel.

Behaviour:
- Reset values:
  - All outputs 0, except rd_burst_len = 16.
  - FIFO is flushed and the unpacker is emptied.
  - The state machine returns to IDLE.
  - Reset applied mid-frame aborts at once; no read_done is issued.
- Command accept:
  - read_req is registered once; the rising edge is the registered value high while the previous registered value is low.
  - In IDLE the rising edge latches read_addr into line_base and clears line_cnt and burst_cnt.
  - The state moves to LINE_START; busy goes to 1.
  - Rising edges in any other state are ignored.
- States:
  - IDLE.
  - LINE_START: clears burst_cnt.
  - BURST_ISSUE:
    - len = min(BURST_LEN, LINE_BURST_NUM - burst_cnt).
    - Wait until FIFO free space (depth - occupancy - beats outstanding) >= len.
    - Then set rd_burst_req = 1, rd_burst_len = len, rd_burst_addr = line_base + {burst_cnt, 3'b000}.
    - burst_cnt += len; outstanding = len; go to BURST_WAIT.
  - BURST_WAIT:
    - rd_burst_req holds high, with len and addr stable, until rd_burst_finish.
    - On finish: rd_burst_req = 0.
    - If burst_cnt == LINE_BURST_NUM: line_cnt += 1, go to LINE_DONE. Otherwise go to BURST_ISSUE.
  - LINE_DONE:
    - line_base += LINE_ADDR_ADD.
    - If line_cnt >= IMG_ROW/SCALE go to DRAIN, else go to LINE_START.
  - DRAIN: wait until the FIFO is empty and the last pixel has been accepted, then go to DONE.
  - DONE: read_done = 1 for one cycle, busy = 0, go to IDLE.
- Burst split at defaults: each line issues bursts of 16, 16 and 8 beats at offsets 0, +128 and +256.
- FIFO write and read:
  - Each cycle with rd_burst_data_valid = 1 writes one word and decrements outstanding.
  - A beat arriving while the FIFO is full is a protocol violation; the word is dropped.
  - Simultaneous write and read in the same cycle is legal, including on a full FIFO.
- Unpacker:
  - Holds one 256-bit word and a 4-bit index; pix_data = word[16*idx +: 16], so bits [15:0] go out first.
  - pix_valid = 1 while a word is held. Index advances on pix_valid & pix_ready.
  - On the transfer at idx 15, the next word is loaded in the same cycle if the FIFO is non-empty, so there is no bubble.
  - pix_data is stable while pix_valid & !pix_ready.
- Latency: pix_valid asserts no later than 3 cycles after the first rd_burst_data_valid of a frame with an empty pipeline.
- Per frame exactly (IMG_COL/SCALE)*(IMG_ROW/SCALE) pixels are output.

Optional Feature:
- Macro: FRAME_READ_MARK_EN.
- Defined: adds outputs pix_eol and pix_eof, both qualified by pix_valid.
  - pix_eol = 1 on the last pixel of each line.
  - pix_eof = 1 on the last pixel of the frame.
  - Both are generated from internal pixel and line counters that clear on command accept.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Defaults, read_addr = 0x0100000, memory model finishes each burst 4 cycles after its last beat, pix_ready = 1 -> first line issues bursts len/addr 16/0x0100000, 16/0x0100080, 8/0x0100100; second line starts at 0x0100280; 360 lines; 230400 pixels; read_done pulses once, after the final pixel.
- IMG_COL = 64, IMG_ROW = 4, SCALE = 1, FIFO_ADDR_WIDTH = 2, pix_ready = 0 -> rd_burst_req stays low after 4 buffered beats (single 4-beat burst); then pix_ready = 1 and the fetch resumes; no beat is lost and the pixel sequence matches memory.
- Beat word 0x...0003_0002_0001 followed by random pix_ready -> pix_data sequence 0x0001, 0x0002, 0x0003, …; each value held stable while not accepted.
- Reset asserted mid-BURST_WAIT on line 2 -> next cycle rd_burst_req = 0, pix_valid = 0, busy = 0; a new read_req then fetches from line 0 of the new read_addr.
- read_req toggled while busy -> ignored; only one read_done per accepted command.
- FRAME_READ_MARK_EN defined, small config (32 pixels × 4 lines) -> pix_eol on pixels 31, 63, 95, 127; pix_eof on pixel 127 only.
